// File: rtl/trigger_fifo_pkg.sv
// Shared constants and helpers for the trigger word FIFO.
package trigger_fifo_pkg;

    localparam int          DATA_W            = 32;
    localparam logic [31:0] TRIGGER_WORD_MARK = 32'h8000_0000;
    localparam logic [7:0]  LOST_COUNT_MAX    = 8'hFF;

    // Address width needed to index a DEPTH-entry storage array.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/trigger_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read.
// A read of the address being written in the same cycle returns the old word.
module trigger_fifo_ram
    import trigger_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write and registered read port; data carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/trigger_word_fifo.sv
// First-word-fall-through FIFO for TLU trigger words. The RAM read port is
// steered to the post-pop read pointer so its output register always holds
// the head word; head_vld tracks whether that register holds a real word.
module trigger_word_fifo
    import trigger_fifo_pkg::*;
#(
    parameter int DEPTH            = 16,
    parameter int NEAR_FULL_MARGIN = 2
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST,
    input  logic              CLEAR,
    input  logic              WR_EN,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              DATA_SAVED_FLAG,
    input  logic              FIFO_READ,
    output logic              FIFO_EMPTY,
    output logic [DATA_W-1:0] FIFO_DATA,
    output logic              FIFO_NEAR_FULL,
    output logic [7:0]        LOST_COUNT,
    output logic              READ_ERROR
);

    localparam int               PTR_W   = ptr_width(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] NF_C    = CNT_W'(DEPTH - NEAR_FULL_MARGIN);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_addr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  remaining;
    logic              head_vld;
    logic              rd_eff;
    logic              wr_acc;
    logic [DATA_W-1:0] stored_word;
    logic [DATA_W-1:0] ram_q;

    // Accept/pop decisions and next-state arithmetic.
    always_comb begin
        rd_eff      = FIFO_READ & head_vld;
        wr_acc      = WR_EN & ~CLEAR & ((count < DEPTH_C) | rd_eff);
        count_next  = count + CNT_W'(wr_acc) - CNT_W'(rd_eff);
        // Words written before this edge are all readable now; a word
        // written at this edge only reaches the head one edge later.
        remaining   = count - CNT_W'(rd_eff);
        rd_addr     = rd_ptr + PTR_W'(rd_eff);
        stored_word = WR_DATA | TRIGGER_WORD_MARK;
    end

    trigger_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (BUS_CLK),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (stored_word),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Pointers, fill count, head validity and status flags.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            head_vld        <= 1'b0;
            DATA_SAVED_FLAG <= 1'b0;
            FIFO_NEAR_FULL  <= 1'b0;
            LOST_COUNT      <= '0;
            READ_ERROR      <= 1'b0;
        end else if (CLEAR) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            head_vld        <= 1'b0;
            DATA_SAVED_FLAG <= 1'b0;
            FIFO_NEAR_FULL  <= 1'b0;
            LOST_COUNT      <= '0;
            READ_ERROR      <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr + PTR_W'(wr_acc);
            rd_ptr          <= rd_addr;
            count           <= count_next;
            head_vld        <= (remaining != '0);
            DATA_SAVED_FLAG <= wr_acc;
            FIFO_NEAR_FULL  <= (count_next >= NF_C);
            if (WR_EN && !wr_acc && LOST_COUNT != LOST_COUNT_MAX) begin
                LOST_COUNT <= LOST_COUNT + 8'd1;
            end
            if (FIFO_READ && !head_vld) begin
                READ_ERROR <= 1'b1;
            end
        end
    end

    assign FIFO_EMPTY = ~head_vld;
    assign FIFO_DATA  = head_vld ? ram_q : '0;

endmodule

// File: tb/tb_trigger_word_fifo.sv
// Directed bench for trigger_word_fifo (DEPTH=16, NEAR_FULL_MARGIN=2).
module tb_trigger_word_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        saved;
    logic        fifo_read;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        near_full;
    logic [7:0]  lost_count;
    logic        read_error;

    int checks   = 0;
    int failures = 0;

    trigger_word_fifo #(.DEPTH(16), .NEAR_FULL_MARGIN(2)) dut (
        .BUS_CLK         (clk),
        .BUS_RST         (rst),
        .CLEAR           (clear),
        .WR_EN           (wr_en),
        .WR_DATA         (wr_data),
        .DATA_SAVED_FLAG (saved),
        .FIFO_READ       (fifo_read),
        .FIFO_EMPTY      (fifo_empty),
        .FIFO_DATA       (fifo_data),
        .FIFO_NEAR_FULL  (near_full),
        .LOST_COUNT      (lost_count),
        .READ_ERROR      (read_error)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; outputs then show the post-edge state.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
        checks++; if (fifo_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", fifo_data); end
        checks++; if (near_full !== 1'b0) begin failures++; $display("FAIL reset_near_full got=%b exp=0", near_full); end
        checks++; if (lost_count !== 8'd0) begin failures++; $display("FAIL reset_lost got=%0d exp=0", lost_count); end
        checks++; if (read_error !== 1'b0) begin failures++; $display("FAIL reset_read_error got=%b exp=0", read_error); end
        checks++; if (saved !== 1'b0) begin failures++; $display("FAIL reset_saved got=%b exp=0", saved); end
    endtask

    task automatic test_single_write();
        wr_en = 1'b1; wr_data = 32'h0000_1234;
        step();
        wr_en = 1'b0;
        checks++; if (saved !== 1'b1) begin failures++; $display("FAIL single_saved got=%b exp=1", saved); end
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL single_empty_early got=%b exp=1", fifo_empty); end
        step();
        checks++; if (saved !== 1'b0) begin failures++; $display("FAIL single_saved_once got=%b exp=0", saved); end
        checks++; if (fifo_empty !== 1'b0) begin failures++; $display("FAIL single_empty_fall got=%b exp=0", fifo_empty); end
        checks++; if (fifo_data !== 32'h8000_1234) begin failures++; $display("FAIL single_data got=%h exp=80001234", fifo_data); end
        fifo_read = 1'b1;
        step();
        fifo_read = 1'b0;
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%b exp=1", fifo_empty); end
        checks++; if (read_error !== 1'b0) begin failures++; $display("FAIL single_no_error got=%b exp=0", read_error); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 19; i++) begin
            wr_en = 1'b1; wr_data = 32'(i);
            step();
            checks++; if (near_full !== (i >= 13)) begin failures++; $display("FAIL fill_near_full i=%0d got=%b exp=%b", i, near_full, (i >= 13)); end
            checks++; if (saved !== (i < 16)) begin failures++; $display("FAIL fill_saved i=%0d got=%b exp=%b", i, saved, (i < 16)); end
            checks++; if (lost_count !== 8'((i >= 16) ? i - 15 : 0)) begin failures++; $display("FAIL fill_lost i=%0d got=%0d", i, lost_count); end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (fifo_empty !== 1'b0 || fifo_data !== (32'h8000_0000 | 32'(i))) begin
                failures++; $display("FAIL fill_drain i=%0d got=%h empty=%b exp=%h", i, fifo_data, fifo_empty, 32'h8000_0000 | 32'(i));
            end
            fifo_read = 1'b1;
            step();
        end
        fifo_read = 1'b0;
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL fill_drained_empty got=%b exp=1", fifo_empty); end
        checks++; if (lost_count !== 8'd3) begin failures++; $display("FAIL fill_lost_final got=%0d exp=3", lost_count); end
    endtask

    task automatic test_read_error_clear();
        fifo_read = 1'b1; wr_en = 1'b1; wr_data = 32'h5;
        step();
        fifo_read = 1'b0; wr_en = 1'b0;
        checks++; if (read_error !== 1'b1) begin failures++; $display("FAIL rderr_set got=%b exp=1", read_error); end
        checks++; if (saved !== 1'b1) begin failures++; $display("FAIL rderr_saved got=%b exp=1", saved); end
        step();
        checks++; if (fifo_empty !== 1'b0 || fifo_data !== 32'h8000_0005) begin failures++; $display("FAIL rderr_word got=%h empty=%b exp=80000005", fifo_data, fifo_empty); end
        checks++; if (read_error !== 1'b1) begin failures++; $display("FAIL rderr_sticky got=%b exp=1", read_error); end
        checks++; if (lost_count !== 8'd3) begin failures++; $display("FAIL rderr_lost_kept got=%0d exp=3", lost_count); end
        clear = 1'b1; wr_en = 1'b1; wr_data = 32'h66; fifo_read = 1'b1;
        step();
        clear = 1'b0; wr_en = 1'b0; fifo_read = 1'b0;
        checks++; if (read_error !== 1'b0) begin failures++; $display("FAIL clear_read_error got=%b exp=0", read_error); end
        checks++; if (lost_count !== 8'd0) begin failures++; $display("FAIL clear_lost got=%0d exp=0", lost_count); end
        checks++; if (saved !== 1'b0) begin failures++; $display("FAIL clear_saved got=%b exp=0", saved); end
        step();
        checks++; if (fifo_empty !== 1'b1 || fifo_data !== 32'h0) begin failures++; $display("FAIL clear_discard got=%h empty=%b exp=0/1", fifo_data, fifo_empty); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 32'h100 + 32'(i);
            step();
        end
        wr_en = 1'b0;
        checks++; if (lost_count !== 8'd1) begin failures++; $display("FAIL full_lost_pre got=%0d exp=1", lost_count); end
        wr_en = 1'b1; wr_data = 32'hAA; fifo_read = 1'b1;
        step();
        wr_en = 1'b0; fifo_read = 1'b0;
        checks++; if (saved !== 1'b1) begin failures++; $display("FAIL full_rw_saved got=%b exp=1", saved); end
        checks++; if (lost_count !== 8'd1) begin failures++; $display("FAIL full_rw_lost got=%0d exp=1", lost_count); end
        checks++; if (near_full !== 1'b1) begin failures++; $display("FAIL full_rw_near_full got=%b exp=1", near_full); end
        wr_en = 1'b1; wr_data = 32'hBB;
        step();
        wr_en = 1'b0;
        checks++; if (saved !== 1'b0 || lost_count !== 8'd2) begin failures++; $display("FAIL full_still_full saved=%b lost=%0d exp=0/2", saved, lost_count); end
        for (int i = 0; i < 16; i++) begin
            automatic logic [31:0] exp = (i < 15) ? (32'h8000_0101 + 32'(i)) : 32'h8000_00AA;
            checks++; if (fifo_empty !== 1'b0 || fifo_data !== exp) begin
                failures++; $display("FAIL full_drain i=%0d got=%h empty=%b exp=%h", i, fifo_data, fifo_empty, exp);
            end
            fifo_read = 1'b1;
            step();
        end
        fifo_read = 1'b0;
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL full_drained_empty got=%b exp=1", fifo_empty); end
    endtask

    task automatic test_back_to_back();
        int bad_data = 0;
        int bad_empty = 0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        wr_en = 1'b1; wr_data = 32'h0;
        step();
        wr_en = 1'b0;
        step();
        checks++; if (fifo_empty !== 1'b0 || fifo_data !== 32'h8000_0000) begin failures++; $display("FAIL b2b_start got=%h empty=%b", fifo_data, fifo_empty); end
        wr_en = 1'b1; wr_data = 32'h1;
        step();
        for (int k = 0; k < 100; k++) begin
            wr_en = 1'b1; wr_data = 32'(k + 2); fifo_read = 1'b1;
            if (fifo_empty !== 1'b0) bad_empty++;
            if (fifo_data !== (32'h8000_0000 | 32'(k))) bad_data++;
            step();
        end
        wr_en = 1'b0; fifo_read = 1'b0;
        checks++; if (bad_empty != 0) begin failures++; $display("FAIL b2b_empty_seen count=%0d exp=0", bad_empty); end
        checks++; if (bad_data != 0) begin failures++; $display("FAIL b2b_order bad=%0d exp=0", bad_data); end
        checks++; if (fifo_data !== 32'h8000_0064) begin failures++; $display("FAIL b2b_tail0 got=%h exp=80000064", fifo_data); end
        fifo_read = 1'b1;
        step();
        fifo_read = 1'b0;
        checks++; if (fifo_empty !== 1'b0 || fifo_data !== 32'h8000_0065) begin failures++; $display("FAIL b2b_tail1 got=%h empty=%b exp=80000065", fifo_data, fifo_empty); end
        checks++; if (lost_count !== 8'd0) begin failures++; $display("FAIL b2b_lost got=%0d exp=0", lost_count); end
        fifo_read = 1'b1;
        step();
        fifo_read = 1'b0;
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL b2b_final_empty got=%b exp=1", fifo_empty); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_data = 32'h40 + 32'(i);
            step();
        end
        wr_en = 1'b0;
        step();
        checks++; if (fifo_empty !== 1'b0) begin failures++; $display("FAIL async_pre_empty got=%b exp=0", fifo_empty); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (fifo_empty !== 1'b1 || fifo_data !== 32'h0) begin failures++; $display("FAIL async_immediate got=%h empty=%b exp=0/1", fifo_data, fifo_empty); end
        checks++; if (near_full !== 1'b0 || lost_count !== 8'd0 || read_error !== 1'b0) begin failures++; $display("FAIL async_status nf=%b lost=%0d err=%b", near_full, lost_count, read_error); end
        step();
        rst = 1'b0;
        wr_en = 1'b1; wr_data = 32'h77;
        step();
        wr_en = 1'b0;
        step();
        checks++; if (fifo_empty !== 1'b0 || fifo_data !== 32'h8000_0077) begin failures++; $display("FAIL async_post_word got=%h empty=%b exp=80000077", fifo_data, fifo_empty); end
        fifo_read = 1'b1;
        step();
        fifo_read = 1'b0;
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL async_only_word got=%b exp=1", fifo_empty); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0; fifo_read = 1'b0;
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_read_error_clear();
        test_full_rw();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
